acc_feed: RTL

- Upstream serializer for the `acc` accumulator.
- Accepts 32-bit words on a valid/ready interface and buffers them in a small FIFO.
- Emits each word as an `add`/`rx` bit-serial frame in the exact format `acc` consumes:
  - `add` high for 33 cycles;
  - one `rx`=0 start bit;
  - 32 data bits, MSB first.
- Sits between the host/command logic and `acc`; `add` and `rx` drive `acc` directly.

---
 rtl/acc_feed_pkg.sv | 16 +
 rtl/acc_feed_fifo.sv | 56 +++++
 rtl/acc_feed.sv | 138 +++++++++++++
 3 files changed

// File: rtl/acc_feed_pkg.sv
// Shared types and frame constants for the acc_feed serializer.
package acc_feed_pkg;

  localparam int unsigned WORD_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic IDLE_RX   = 1'b1;

endpackage

// File: rtl/acc_feed_fifo.sv
// Synchronous word FIFO with registered occupancy and registered not_full/empty flags.
module acc_feed_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             not_full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push_ok;
  logic             pop_ok;

  // Full blocks pushes and empty blocks pops, whatever the requesters do.
  always_comb begin
    push_ok   = push & not_full;
    pop_ok    = pop & ~empty;
    count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  end

  assign rdata_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b1;
      empty    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      not_full <= (count_nxt != CW'(DEPTH));
      empty    <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/acc_feed.sv
// Word-to-serial frame feeder for acc: add strobe + start bit + MSB-first data.
// Optional completed-frame counter enabled by defining ACC_FEED_COUNT_EN.
module acc_feed
  import acc_feed_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              add,
  output logic              rx,
  output logic              busy
`ifdef ACC_FEED_COUNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE  = 2'(acc_feed_pkg::IDLE);
  localparam logic [1:0] S_START = 2'(acc_feed_pkg::START);
  localparam logic [1:0] S_SHIFT = 2'(acc_feed_pkg::SHIFT);
  localparam logic [1:0] S_GAP   = 2'(acc_feed_pkg::GAP);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic [WORD_W-1:0] sr, sr_nxt;
  logic              add_nxt, rx_nxt, busy_nxt;
  logic              pop;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rdata_c;
`ifdef ACC_FEED_COUNT_EN
  logic              frame_done;
`endif

  acc_feed_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .pop      (pop),
    .wdata    (in_word),
    .rdata_c  (fifo_rdata_c),
    .not_full (in_ready),
    .empty    (fifo_empty)
  );

  // Outputs are registered from the current state, so each state shows on the pins one cycle later.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    sr_nxt      = sr;
    pop         = 1'b0;
    add_nxt     = 1'b0;
    rx_nxt      = IDLE_RX;
    busy_nxt    = (state != S_IDLE) | ~fifo_empty;
`ifdef ACC_FEED_COUNT_EN
    frame_done  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          sr_nxt    = fifo_rdata_c;
          state_nxt = S_START;
        end
      end
      S_START: begin
        add_nxt     = 1'b1;
        rx_nxt      = START_BIT;
        bit_cnt_nxt = CNT_W'(WORD_W - 1);
        state_nxt   = S_SHIFT;
      end
      S_SHIFT: begin
        add_nxt = 1'b1;
        rx_nxt  = sr[bit_cnt];
        if (bit_cnt == '0) begin
`ifdef ACC_FEED_COUNT_EN
          frame_done = 1'b1;
`endif
          if (GAP == 0) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt   = S_GAP;
            gap_cnt_nxt = GAP_W'(GAP - 1);
          end
        end else begin
          bit_cnt_nxt = bit_cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = S_IDLE;
        else               gap_cnt_nxt = gap_cnt - GAP_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sr      <= '0;
      add     <= 1'b0;
      rx      <= IDLE_RX;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      sr      <= sr_nxt;
      add     <= add_nxt;
      rx      <= rx_nxt;
      busy    <= busy_nxt;
    end
  end

`ifdef ACC_FEED_COUNT_EN
  // Counts frames that reached SHIFT exit; truncated frames never get there.
  always_ff @(posedge clk) begin
    if (rst)             frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule
